// File: rtl/seq_det_pkg.sv
// Shared "1011" detector definitions: state encoding and the single-step
// transition function used by the RTL step module and by the bench.
package seq_det_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_S1    = 3'd1,
        ST_S10   = 3'd2,
        ST_S101  = 3'd3,
        ST_S1011 = 3'd4
    } det_state_e;

    // The argument is raw 3-bit state so codes 5-7 can be fed in and recover to IDLE
    function automatic det_state_e det_step(input logic [2:0] state, input logic in_bit);
        det_state_e nxt;
        case (state)
            3'd0:    nxt = in_bit ? ST_S1    : ST_IDLE;
            3'd1:    nxt = in_bit ? ST_S1    : ST_S10;
            3'd2:    nxt = in_bit ? ST_S101  : ST_IDLE;
            3'd3:    nxt = in_bit ? ST_S1011 : ST_S10;
            3'd4:    nxt = in_bit ? ST_S1    : ST_S10;
            default: nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/seq1011_step.sv
// Combinational single step of the "1011" Moore detector: (state, bit) -> (next, hit).
module seq1011_step
    import seq_det_pkg::*;
(
    input  logic [2:0] i_state,
    input  logic       i_bit,
    output det_state_e o_next,
    output logic       o_hit
);

    // Next state from the shared transition function; hit when it lands in S1011
    always_comb begin
        o_next = det_step(i_state, i_bit);
        o_hit  = (o_next == ST_S1011);
    end

endmodule

// File: rtl/seq1011_chan_sched.sv
// Time-multiplexed "1011" detector: a round-robin arbiter picks one serial
// channel per cycle, one shared step module advances that channel's saved
// state, and per-channel saturating counters record completions.
module seq1011_chan_sched
    import seq_det_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int CNT_W  = 8,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] req_valid,
    input  logic [NUM_CH-1:0] req_bit,
    output logic [NUM_CH-1:0] req_ready,
    output logic              hit_valid,
    output logic [CH_W-1:0]   hit_chan,
    input  logic              clr_counts,
    input  logic [CH_W-1:0]   cnt_sel,
    output logic [CNT_W-1:0]  cnt_val
);

    det_state_e          r_state [NUM_CH];
    logic [CNT_W-1:0]    r_cnt   [NUM_CH];
    logic [CH_W-1:0]     r_ptr;
    logic                r_hit_valid;
    logic [CH_W-1:0]     r_hit_chan;

    logic                w_gnt_any;
    logic [CH_W-1:0]     w_gnt_idx;
    logic [CH_W-1:0]     w_ptr_nxt;
    logic [2:0]          w_cur_state;
    det_state_e          w_next_state;
    logic                w_step_hit;
    logic                w_hit;

    // Round-robin search: first valid channel at or after the pointer, wrapping
    always_comb begin
        int unsigned v_idx;
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        req_ready = '0;
        v_idx     = 0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            v_idx = (int'(r_ptr) + int'(k)) % NUM_CH;
            if (!w_gnt_any && req_valid[v_idx]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = CH_W'(v_idx);
            end
        end
        if (w_gnt_any) begin
            req_ready[w_gnt_idx] = 1'b1;
        end
        w_ptr_nxt = (w_gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : w_gnt_idx + CH_W'(1);
    end

    assign w_cur_state = r_state[w_gnt_idx];
    assign w_hit       = w_gnt_any & w_step_hit;

    seq1011_step u_step (
        .i_state (w_cur_state),
        .i_bit   (req_bit[w_gnt_idx]),
        .o_next  (w_next_state),
        .o_hit   (w_step_hit)
    );

    // Advance only the granted channel's saved state and move the pointer past it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                r_state[k] <= ST_IDLE;
            end
            r_ptr <= '0;
        end else if (w_gnt_any) begin
            r_state[w_gnt_idx] <= w_next_state;
            r_ptr              <= w_ptr_nxt;
        end
    end

    // Registered hit pulse; channel index holds between hits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hit_valid <= 1'b0;
            r_hit_chan  <= '0;
        end else begin
            r_hit_valid <= w_hit;
            if (w_hit) begin
                r_hit_chan <= w_gnt_idx;
            end
        end
    end

    // Saturating hit counters; a clear on the same edge beats the increment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (clr_counts) begin
                    r_cnt[k] <= '0;
                end else if (w_hit && (w_gnt_idx == CH_W'(k)) && (r_cnt[k] != '1)) begin
                    r_cnt[k] <= r_cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    assign hit_valid = r_hit_valid;
    assign hit_chan  = r_hit_chan;
    assign cnt_val   = r_cnt[cnt_sel];

endmodule
